ej32_mem_arb: RTL and testbench
===============================

Name: ej32_mem_arb

Overview:
Arbitrates the single 8-bit SPRAM port (mb8 slave side, neg-edge RAM, 1-cycle read latency) between NREQ requesters.
- Default requester map: 0 = ROM boot loader, 1 = instruction fetch, 2 = load/store unit, 3 = debug/host port.
- Round-robin grant, with byte bursts of 1..4 beats so the LS unit can move a 32-bit word without interleaving.
- Sits between the EJ32 core units and spram8_128k.

Parameters:
NREQ, 4, number of requesters (2..8)
ASZ, 17, byte address width (128 KB SPRAM)
LSZ, 3, burst-length field width; max burst 4 beats

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
req_v  in  NREQ  request valid per requester
req_we  in  NREQ  1 = write burst, 0 = read burst
req_a  in  NREQ*ASZ  burst base byte address, packed, requester i at [i*ASZ +: ASZ]
req_len  in  NREQ*LSZ  beats, packed; 0 is treated as 1, values >4 are clamped to 4
req_d  in  NREQ*8  write byte for the current beat, packed
gnt  out  NREQ  one-hot; owner of the port for the whole burst
ack  out  NREQ  one-hot; the requester's current beat was issued this cycle
rd  out  8  read data from RAM
rvld  out  NREQ  one-hot; rd is valid for this requester
mem_cs  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_a  out  ASZ  RAM byte address
mem_d  out  8  RAM write data
mem_q  in  8  RAM read data, valid the cycle after a read issue
busy  out  1  state is not IDLE

Behaviour:
Reset (rst = 0 at a posedge):
- state = IDLE, rr_ptr = 0.
- gnt, ack, rvld, mem_cs, mem_we, busy = 0; mem_a, mem_d, rd = 0.
- Applies mid-burst: the access is dropped at once, and no rvld is produced for an already-issued read.

FSM: IDLE -> BURST -> IDLE. All outputs are registered.
- IDLE: if any req_v is set, pick the winner. The winner is the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch owner, base address, we, and beat count n = clamp(len).
  - Set gnt[owner], go to BURST.
  - If no req_v is set, stay in IDLE.
- BURST, beat k (0..n-1), one beat per cycle:
  - mem_cs = 1, mem_a = base + k (modulo 2^ASZ, wraps at the top of memory), mem_we = latched we, mem_d = req_d[owner].
  - ack[owner] = 1.
  - The requester presents the next write byte in the cycle after each ack.
  - On the last beat: gnt is cleared, rr_ptr = owner + 1 (mod NREQ), and the FSM returns to IDLE.
  - This gives one mandatory idle cycle between bursts.
- Read return: for a read beat issued in cycle C, rd = mem_q and rvld[owner] = 1 in cycle C+1. This holds even if the FSM has already returned to IDLE.
- Latency: req_v sampled at edge N gives gnt at N+1, first beat at N+2, first rvld at N+3.
- Abort: if req_v[owner] drops during BURST, the current cycle issues no beat (mem_cs = 0). The FSM returns to IDLE with rr_ptr advanced, and outstanding read data is still returned.
- Handshake rule: req_a, req_we and req_len are sampled only in IDLE. Changes during a burst are ignored.
- Non-owners see gnt = ack = rvld = 0 and must hold their req_v.
- Under continuous requests, no requester waits more than (NREQ-1) bursts.

Optional Feature:
EJ32_ARB_PRIO0_EN
- Defined: requester 0 has absolute priority in IDLE. Whenever req_v[0] = 1 it wins, regardless of rr_ptr, and rr_ptr is not advanced by its bursts. Bursts in flight are never preempted. This is used so the ROM image copy completes before the decoder is enabled.
- Undefined: requester 0 takes part in plain round-robin like every other requester.

Test Plan:
1. Single read: rst released; req_v = 0010, req_a[1] = 0x00100, len = 1, RAM[0x100] = 0xA5 -> gnt = 0010 at N+1; mem_a = 0x00100 with ack at N+2; rd = 0xA5 and rvld = 0010 at N+3; busy deasserts after the beat.
2. Word write burst: requester 2, we = 1, base 0x1FFFE, len = 4, bytes 11,22,33,44 -> mem_a = 1FFFE, 1FFFF, 00000, 00001 (wrap) on 4 consecutive cycles, each with mem_we = 1 and ack = 0100.
3. Round-robin: req_v = 1111 held with len = 1 -> grants in order 0,1,2,3,0 with one idle cycle between bursts; with EJ32_ARB_PRIO0_EN defined, every grant goes to 0.
4. Abort: requester 3 read, len = 4; req_v[3] dropped after the 2nd ack -> exactly 2 mem_cs beats and 2 rvld pulses; FSM in IDLE on the next cycle; next grant goes to requester 0.
5. Reset mid-burst: rst = 0 during beat 1 of a 4-beat read -> next cycle mem_cs = 0, gnt = 0, rvld = 0, busy = 0; after release, rr_ptr = 0.
6. len = 0 and len = 7 -> 1 beat and 4 beats issued, respectively.

Source files
------------

// File: rtl/ej32_mem_arb.sv
// ej32_mem_arb: round-robin arbiter for the single 8-bit SPRAM port, 1..4-beat byte bursts.
// Optional: define EJ32_ARB_PRIO0_EN to give requester 0 absolute priority in IDLE.
module ej32_mem_arb #(
  parameter int NREQ = 4,
  parameter int ASZ  = 17,
  parameter int LSZ  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_v,
  input  logic [NREQ-1:0]     req_we,
  input  logic [NREQ*ASZ-1:0] req_a,
  input  logic [NREQ*LSZ-1:0] req_len,
  input  logic [NREQ*8-1:0]   req_d,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     ack,
  output logic [7:0]          rd,
  output logic [NREQ-1:0]     rvld,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ASZ-1:0]      mem_a,
  output logic [7:0]          mem_d,
  input  logic [7:0]          mem_q,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state, w_state;
  logic [PW-1:0]   r_ptr, w_ptr, r_own, w_own, w_win, w_adv;
  logic [ASZ-1:0]  r_addr, w_addr, w_mem_a;
  logic            r_we, w_we, w_found, w_mem_cs, w_mem_we;
  logic [2:0]      r_left, w_left;
  logic [NREQ-1:0] w_gnt, w_ack, w_rvld;
  logic [7:0]      w_mem_d, w_rd;
  int unsigned     w_dist, w_best;

  function automatic logic [2:0] f_beats(input logic [LSZ-1:0] len);
    if (len == '0)
      return 3'd1;
    else if (32'(len) > 32'd4)
      return 3'd4;
    else
      return 3'(len);
  endfunction

  // Winner = requester with the smallest circular distance from r_ptr.
  always_comb begin : pick
    w_found = 1'b0;
    w_win   = '0;
    w_best  = 32'(NREQ);
    w_dist  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      w_dist = (j >= 32'(r_ptr)) ? j - 32'(r_ptr) : j + 32'(NREQ) - 32'(r_ptr);
      if (req_v[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_win   = PW'(j);
        w_found = 1'b1;
      end
    end
`ifdef EJ32_ARB_PRIO0_EN
    if (req_v[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_comb begin : adv
    w_adv = (32'(r_own) == 32'(NREQ - 1)) ? '0 : r_own + PW'(1);
`ifdef EJ32_ARB_PRIO0_EN
    if (r_own == '0) w_adv = r_ptr;
`endif
  end

  always_comb begin : next
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_own    = r_own;
    w_addr   = r_addr;
    w_we     = r_we;
    w_left   = r_left;
    w_gnt    = gnt;
    w_ack    = '0;
    w_mem_cs = 1'b0;
    w_mem_we = 1'b0;
    w_mem_a  = mem_a;
    w_mem_d  = mem_d;
    // Read data returns the cycle after its beat, whatever the FSM is doing now.
    w_rvld   = (mem_cs && !mem_we) ? ack : '0;
    w_rd     = (mem_cs && !mem_we) ? mem_q : rd;
    case (r_state)
      S_IDLE: begin
        w_gnt = '0;
        if (w_found) begin
          w_state      = S_BURST;
          w_own        = w_win;
          w_addr       = req_a[w_win*ASZ +: ASZ];
          w_we         = req_we[w_win];
          w_left       = f_beats(req_len[w_win*LSZ +: LSZ]);
          w_gnt[w_win] = 1'b1;
        end
      end
      S_BURST: begin
        if (!req_v[r_own]) begin
          w_state = S_IDLE;
          w_gnt   = '0;
          w_ptr   = w_adv;
        end else begin
          w_mem_cs     = 1'b1;
          w_mem_we     = r_we;
          w_mem_a      = r_addr;
          w_mem_d      = req_d[r_own*8 +: 8];
          w_ack[r_own] = 1'b1;
          w_addr       = r_addr + ASZ'(1);
          w_left       = r_left - 3'd1;
          if (r_left == 3'd1) begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_ptr   = w_adv;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_left  <= '0;
      gnt     <= '0;
      ack     <= '0;
      rvld    <= '0;
      rd      <= '0;
      mem_cs  <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_d   <= '0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_own   <= w_own;
      r_addr  <= w_addr;
      r_we    <= w_we;
      r_left  <= w_left;
      gnt     <= w_gnt;
      ack     <= w_ack;
      rvld    <= w_rvld;
      rd      <= w_rd;
      mem_cs  <= w_mem_cs;
      mem_we  <= w_mem_we;
      mem_a   <= w_mem_a;
      mem_d   <= w_mem_d;
      busy    <= (w_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Scoreboard bench for ej32_mem_arb: expected beats/read returns queued at drive time, popped at negedge.
module tb_ej32_mem_arb;
  localparam int NREQ = 4;
  localparam int ASZ  = 17;
  localparam int LSZ  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_v, req_we;
  logic [NREQ*ASZ-1:0] req_a;
  logic [NREQ*LSZ-1:0] req_len;
  logic [NREQ*8-1:0]   req_d;
  logic [NREQ-1:0]     gnt, ack, rvld;
  logic [7:0]          rd, mem_d, mem_q;
  logic                mem_cs, mem_we, busy;
  logic [ASZ-1:0]      mem_a;

  always #5 clk = ~clk;

  ej32_mem_arb #(.NREQ(NREQ), .ASZ(ASZ), .LSZ(LSZ)) dut (
    .clk(clk), .rst(rst), .req_v(req_v), .req_we(req_we), .req_a(req_a),
    .req_len(req_len), .req_d(req_d), .gnt(gnt), .ack(ack), .rd(rd), .rvld(rvld),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
    .busy(busy)
  );

  // Neg-edge SPRAM model; shadow is the bench's own view of memory contents.
  logic [7:0] ram    [0:(1<<ASZ)-1];
  logic [7:0] shadow [0:(1<<ASZ)-1];
  always @(negedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_a] = mem_d;
      else        mem_q = ram[mem_a];
    end
  end

  int n_chk = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [1:0] own; logic we; logic [16:0] a; logic [7:0] d; } beat_t;
  typedef struct packed { logic [1:0] own; logic [7:0] d; } rv_t;
  beat_t q_beat[$];
  rv_t   q_rv[$];
  beat_t mb;
  rv_t   mr;

  function automatic logic [3:0] oh(input int i);
    return 4'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input int own, input logic we, input logic [16:0] a,
                              input int n, input logic [31:0] wd);
    beat_t b;
    rv_t   r;
    for (int k = 0; k < n; k++) begin
      b.own = 2'(own);
      b.we  = we;
      b.a   = a + 17'(k);
      b.d   = wd[8*k +: 8];
      q_beat.push_back(b);
      if (we) shadow[b.a] = b.d;
      else begin
        r.own = 2'(own);
        r.d   = shadow[b.a];
        q_rv.push_back(r);
      end
    end
  endtask

  task automatic sb_drain(input string tag);
    check(tag, 32'(q_beat.size() + q_rv.size()), 0);
    q_beat.delete();
    q_rv.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_cs) begin
        if (q_beat.size() == 0) check("beat_unexpected", 32'(q_beat.size()), 1);
        else begin
          mb = q_beat.pop_front();
          check("mem_a", 32'(mem_a), 32'(mb.a));
          check("mem_we", 32'(mem_we), 32'(mb.we));
          check("ack", 32'(ack), 32'(oh(mb.own)));
          if (mb.we) check("mem_d", 32'(mem_d), 32'(mb.d));
        end
      end else check("ack_idle", 32'(ack), 0);
      if (rvld != '0) begin
        if (q_rv.size() == 0) check("rvld_unexpected", 32'(q_rv.size()), 1);
        else begin
          mr = q_rv.pop_front();
          check("rvld", 32'(rvld), 32'(oh(mr.own)));
          check("rd", 32'(rd), 32'(mr.d));
        end
      end
    end
  end

  task automatic burst(input int own, input logic we, input logic [16:0] a,
                       input logic [2:0] len, input int n, input logic [31:0] wd);
    int cnt, cyc;
    expect_burst(own, we, a, n, wd);
    req_we[own]          = we;
    req_a[own*ASZ +: ASZ] = a;
    req_len[own*LSZ +: LSZ] = len;
    req_d[own*8 +: 8]    = wd[7:0];
    req_v[own]           = 1'b1;
    tick();
    check("gnt", 32'(gnt), 32'(oh(own)));
    check("busy_gnt", 32'(busy), 1);
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 20) begin
      tick();
      cyc++;
      if (ack[own]) begin
        cnt++;
        if (cnt < n) req_d[own*8 +: 8] = wd[8*cnt +: 8];
      end
    end
    req_v[own] = 1'b0;
    check("burst_cycles", 32'(cyc), 32'(n));
    check("busy_end", 32'(busy), 0);
    check("gnt_end", 32'(gnt), 0);
    tick();
    if (!we) check("rvld_lat", 32'(rvld), 32'(oh(own)));
    tick();
    sb_drain("sb_empty");
  endtask

  int ord[5];
  int g, gap, cyc, cnt;

  initial begin
    rst = 1'b0; req_v = '0; req_we = '0; req_a = '0; req_len = '0; req_d = '0; mem_q = '0;
    for (int i = 0; i < (1 << ASZ); i++) begin
      ram[i]    = 8'(i * 7 + 3);
      shadow[i] = ram[i];
    end
    ram[17'h100]    = 8'hA5;
    shadow[17'h100] = 8'hA5;

    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 0);   check("rst_ack", 32'(ack), 0);
    check("rst_rvld", 32'(rvld), 0); check("rst_cs", 32'(mem_cs), 0);
    check("rst_we", 32'(mem_we), 0); check("rst_busy", 32'(busy), 0);
    check("rst_a", 32'(mem_a), 0);   check("rst_d", 32'(mem_d), 0);
    check("rst_rd", 32'(rd), 0);
    rst = 1'b1;
    tick();
    mon_en = 1'b1;

    // Round-robin with all four requesting, len = 1
    for (int k = 0; k < 5; k++) begin
`ifdef EJ32_ARB_PRIO0_EN
      ord[k] = 0;
`else
      ord[k] = k % 4;
`endif
    end
    for (int i = 0; i < 4; i++) begin
      req_a[i*ASZ +: ASZ]   = 17'h10 + 17'(i);
      req_len[i*LSZ +: LSZ] = 3'd1;
    end
    for (int k = 0; k < 5; k++) expect_burst(ord[k], 1'b0, 17'h10 + 17'(ord[k]), 1, 0);
    req_v = 4'hF;
    g = 0; gap = 0; cyc = 0;
    while (g < 5 && cyc < 30) begin
      tick();
      cyc++;
      gap++;
      if (gnt != '0) begin
        check("rr_gnt", 32'(gnt), 32'(oh(ord[g])));
        if (g > 0) check("rr_gap", 32'(gap), 2);
        gap = 0;
        g++;
      end
    end
    check("rr_count", 32'(g), 5);
    req_v = oh(ord[4]);
    tick();
    check("rr_last_ack", 32'(ack), 32'(oh(ord[4])));
    req_v = '0;
    tick(); tick();
    sb_drain("rr_sb");

    // Single read, word write with address wrap, read-back
    burst(1, 1'b0, 17'h00100, 3'd1, 1, 0);
    burst(2, 1'b1, 17'h1FFFE, 3'd4, 4, 32'h44332211);
    burst(2, 1'b0, 17'h1FFFE, 3'd4, 4, 0);

    // Abort: requester 3 drops req_v after its 2nd ack
    req_a[3*ASZ +: ASZ] = 17'h200; req_len[3*LSZ +: LSZ] = 3'd4;
    req_a[0*ASZ +: ASZ] = 17'h20;  req_len[0*LSZ +: LSZ] = 3'd1;
    req_a[1*ASZ +: ASZ] = 17'h30;  req_len[1*LSZ +: LSZ] = 3'd1;
    req_we = '0;
    expect_burst(3, 1'b0, 17'h200, 2, 0);
    expect_burst(0, 1'b0, 17'h20, 1, 0);
    expect_burst(1, 1'b0, 17'h30, 1, 0);
    req_v = 4'b1000;
    tick();
    check("ab_gnt", 32'(gnt), 32'h8);
    req_v = 4'b1011;
    cnt = 0; cyc = 0;
    while (cnt < 2 && cyc < 10) begin
      tick();
      cyc++;
      if (ack[3]) cnt++;
    end
    check("ab_acks", 32'(cnt), 2);
    req_v[3] = 1'b0;
    tick();
    check("ab_cs", 32'(mem_cs), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_gnt0", 32'(gnt), 0);
    tick();
    check("ab_next", 32'(gnt), 32'h1);
    tick();
    check("ab_ack0", 32'(ack), 32'h1);
    req_v[0] = 1'b0;
    tick();
    check("ab_gnt1", 32'(gnt), 32'h2);
    tick();
    req_v[1] = 1'b0;
    tick(); tick();
    sb_drain("ab_sb");

    // Reset during beat 1 of a 4-beat read
    req_a[2*ASZ +: ASZ] = 17'h300; req_len[2*LSZ +: LSZ] = 3'd4;
    expect_burst(2, 1'b0, 17'h300, 2, 0);
    void'(q_rv.pop_back());
    req_v = 4'b0100;
    tick();
    check("rs_gnt", 32'(gnt), 32'h4);
    tick();
    check("rs_ack0", 32'(ack), 32'h4);
    tick();
    check("rs_ack1", 32'(ack), 32'h4);
    rst = 1'b0;
    tick();
    check("rs_cs", 32'(mem_cs), 0);   check("rs_gnt0", 32'(gnt), 0);
    check("rs_rvld", 32'(rvld), 0);   check("rs_busy", 32'(busy), 0);
    check("rs_ack", 32'(ack), 0);
    req_v = '0;
    rst = 1'b1;
    tick();
    expect_burst(0, 1'b0, 17'h20, 1, 0);
    req_v = 4'b1001;
    tick();
    check("rs_ptr", 32'(gnt), 32'h1);
    req_v = 4'b0001;
    tick();
    check("rs_ack_after", 32'(ack), 32'h1);
    req_v = '0;
    tick(); tick();
    sb_drain("rs_sb");

    // Length clamping
    burst(1, 1'b0, 17'h400, 3'd0, 1, 0);
    burst(3, 1'b1, 17'h500, 3'd7, 4, 32'hDDCCBBAA);
    burst(3, 1'b0, 17'h500, 3'd4, 4, 0);
    burst(0, 1'b0, 17'h600, 3'd5, 4, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
